uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Receive-side byte buffer between the UART receiver and the bus-facing UART peripheral. It captures each byte the receiver flags as ready into a DEPTH-entry circular FIFO and returns bytes one at a time on CPU read requests. It also provides occupancy, full/empty, threshold and sticky overrun status for the peripheral's control/status register. The FIFO decouples CPU polling latency from line rate, so back-to-back frames at 115200 baud are not lost.

## Interface
- DEPTH, 16: number of byte entries; power of two, ≥ 2.
- THRESH, 8: level at which `thresh` asserts; 1 ≤ THRESH ≤ DEPTH.
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- in_data  in  8  receiver byte; stable while `in_ready` is high.
- in_ready  in  1  receiver ready level; each rising edge is one new byte.
- rd_en  in  1  single-cycle read request from the peripheral.
- flush  in  1  synchronous clear of contents and flags.
- clr_ovr  in  1  synchronous clear of `overrun`.
- rd_data  out  8  registered read byte.
- rd_valid  out  1  one-cycle pulse; `rd_data` was updated this cycle.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- thresh  out  1  count ≥ THRESH.
- overrun  out  1  sticky: a byte was dropped because the FIFO was full.

## Operation
- Edge detect: register `in_ready_d`, reset value 1. A write request is `in_ready & ~in_ready_d`. A level that is already high when reset releases is not captured.
- Storage: DEPTH×8 array, write pointer `wp`, read pointer `rp`, each $clog2(DEPTH) bits. Pointers wrap modulo DEPTH by natural overflow. `count` is held as a separate register.
- Read accepted: `rd_en & ~empty`. The array is read at `rp`, the result is registered into `rd_data`, `rp` increments, and `rd_valid` pulses.
- Read on empty: ignored. `rd_data` holds its value, `rd_valid` stays 0, and no flag is set.
- Write accepted: a write request when `~full`, or when `full` and a read is accepted in the same cycle. `in_data` is stored at `wp` and `wp` increments.
- Write on full with no read accepted: the byte is dropped, the pointers are unchanged, and `overrun` is set to 1.
- Simultaneous accepted read and write: `count` is unchanged and both pointers advance.
- Simultaneous write and read with `empty`: the write is accepted and the read is ignored. There is no bypass; the byte becomes readable on the next cycle.
- `flush`: sets `wp`, `rp` and `count` to 0 and clears `overrun`. Flush has priority over writes, reads and `clr_ovr` in the same cycle. A write request in the flush cycle is discarded, and `rd_valid` is 0 in that cycle.
- `clr_ovr`: clears `overrun`. If an overrun drop happens in the same cycle, set wins and `overrun` stays 1.
- Array contents are not reset; only the pointers, count and flags are.

## Timing
- Reset values (asynchronous, while `rst_n` = 0): rd_data 8'h00, rd_valid 0, count 0, empty 1, full 0, thresh 0, overrun 0, wp = rp = 0, in_ready_d 1.
- `count`, `empty`, `full` and `thresh` are registered or derived from registered `count`. They update on the clock edge after the accepting cycle.
- Write latency: rising `in_ready` sampled at edge N. The byte is stored at edge N, `count` and `empty` reflect it after edge N, and it is readable with `rd_en` in cycle N+1.
- Read latency: `rd_en` high in cycle N with `empty` = 0. `rd_data` and `rd_valid` are valid after edge N, i.e. one cycle. `rd_en` held high reads one byte per cycle until empty.
- Reset asserted mid-operation returns to the reset state immediately. Bytes in flight are lost.

## Test plan
- Reset with `in_ready` = 1, then release: count 0, empty 1, no write until `in_ready` falls and rises again.
- Write 8'hA5, 8'h3C, then 2×`rd_en`: rd_data is A5 then 3C, each with a `rd_valid` pulse; count goes 2→1→0 and empty ends 1.
- Write 16 bytes 8'h00..8'h0F: full 1 and thresh 1 from count 8. A 17th byte 8'hFF is dropped, so overrun 1; reading all 16 returns 00..0F in order. Then `clr_ovr` gives overrun 0.
- FIFO full, write 8'h77 and `rd_en` in the same cycle: the oldest byte is read, 77 is accepted, count stays 16, overrun stays 0.
- Fill 10 bytes, read 10, write 10 more so the pointers wrap past 15: output order is preserved and count tracks 0..10 exactly.
- Count 5 and overrun 1, assert `flush` together with a write and `rd_en`: next cycle count 0, empty 1, overrun 0, rd_valid 0, and the written byte is discarded.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: DEPTH-entry circular byte FIFO between the UART receiver and the CPU-facing peripheral.
// Latency: a byte is readable one cycle after its in_ready rising edge; rd_data/rd_valid follow rd_en by one cycle.
// Backpressure: none toward the receiver; a byte arriving while full is dropped and flagged in sticky overrun.
module uart_rx_fifo #(
    parameter int DEPTH  = 16,
    parameter int THRESH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             in_data,
    input  logic                   in_ready,
    input  logic                   rd_en,
    input  logic                   flush,
    input  logic                   clr_ovr,
    output logic [7:0]             rd_data,
    output logic                   rd_valid,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full,
    output logic                   thresh,
    output logic                   overrun
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [CW-1:0] r_count;
    logic          r_in_ready_d;
    logic [7:0]    r_rd_data;
    logic          r_rd_valid;
    logic          r_overrun;

    logic w_wr_req;
    logic w_empty;
    logic w_full;
    logic w_rd_acc;
    logic w_wr_acc;
    logic w_drop;

    // in_ready_d resets high so a level already high at reset release is not taken as a new byte.
    assign w_wr_req = in_ready & ~r_in_ready_d;
    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == CW'(DEPTH));

    // Flush overrides everything; a full FIFO still accepts a write when a read frees a slot in the same cycle.
    assign w_rd_acc = rd_en & ~w_empty & ~flush;
    assign w_wr_acc = w_wr_req & (~w_full | w_rd_acc) & ~flush;
    assign w_drop   = w_wr_req & w_full & ~w_rd_acc & ~flush;

    // Storage array: written on accepted writes only, never reset.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wp] <= in_data;
        end
    end

    // Pointers, occupancy, read data register and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp         <= '0;
            r_rp         <= '0;
            r_count      <= '0;
            r_in_ready_d <= 1'b1;
            r_rd_data    <= 8'h00;
            r_rd_valid   <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_in_ready_d <= in_ready;
            r_rd_valid   <= w_rd_acc;
            if (flush) begin
                r_wp      <= '0;
                r_rp      <= '0;
                r_count   <= '0;
                r_overrun <= 1'b0;
            end else begin
                if (w_rd_acc) begin
                    r_rd_data <= r_mem[r_rp];
                    r_rp      <= r_rp + AW'(1);
                end
                if (w_wr_acc) begin
                    r_wp <= r_wp + AW'(1);
                end
                if (w_wr_acc && !w_rd_acc) begin
                    r_count <= r_count + CW'(1);
                end else if (w_rd_acc && !w_wr_acc) begin
                    r_count <= r_count - CW'(1);
                end
                // A drop in the same cycle as clr_ovr keeps the flag set.
                if (w_drop) begin
                    r_overrun <= 1'b1;
                end else if (clr_ovr) begin
                    r_overrun <= 1'b0;
                end
            end
        end
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign count    = r_count;
    assign empty    = w_empty;
    assign full     = w_full;
    assign thresh   = (r_count >= CW'(THRESH));
    assign overrun  = r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed scenarios plus randomized traffic against a queue-based reference model.
// Latency: model is updated at each clock edge and compared 1 time unit later.
// Backpressure: none; stimulus freely overfills and overdrains the FIFO.
module tb_uart_rx_fifo;
    localparam int DEPTH  = 16;
    localparam int THRESH = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_ready = 1'b0;
    logic       rd_en = 1'b0;
    logic       flush = 1'b0;
    logic       clr_ovr = 1'b0;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [4:0] count;
    logic       empty;
    logic       full;
    logic       thresh;
    logic       overrun;

    uart_rx_fifo #(.DEPTH(DEPTH), .THRESH(THRESH)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_ready(in_ready),
        .rd_en(rd_en), .flush(flush), .clr_ovr(clr_ovr),
        .rd_data(rd_data), .rd_valid(rd_valid), .count(count),
        .empty(empty), .full(full), .thresh(thresh), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: byte queue, sticky overrun, last read byte, receiver level history.
    logic [7:0] q[$];
    bit         m_prev;
    bit         m_ovr;
    bit         m_vld;
    logic [7:0] m_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        check("count",    32'(count),    32'(q.size()));
        check("empty",    32'(empty),    32'(q.size() == 0));
        check("full",     32'(full),     32'(q.size() == DEPTH));
        check("thresh",   32'(thresh),   32'(q.size() >= THRESH));
        check("overrun",  32'(overrun),  32'(m_ovr));
        check("rd_valid", 32'(rd_valid), 32'(m_vld));
        check("rd_data",  32'(rd_data),  32'(m_data));
    endtask

    // One clock cycle with the given inputs; the model applies the FIFO rules at the edge.
    task automatic cyc(input bit ir, input logic [7:0] d, input bit rd, input bit fl, input bit co);
        bit wr_req;
        bit rd_acc;
        bit was_full;
        in_ready = ir; in_data = d; rd_en = rd; flush = fl; clr_ovr = co;
        @(posedge clk);
        wr_req = ir && !m_prev;
        m_prev = ir;
        if (fl) begin
            q.delete();
            m_ovr = 1'b0;
            m_vld = 1'b0;
        end else begin
            was_full = (q.size() == DEPTH);
            rd_acc   = rd && (q.size() != 0);
            m_vld    = rd_acc;
            if (rd_acc) m_data = q.pop_front();
            if (co) m_ovr = 1'b0;
            if (wr_req) begin
                if (!was_full || rd_acc) q.push_back(d);
                else m_ovr = 1'b1;
            end
        end
        #1;
        check_all();
    endtask

    task automatic wr(input logic [7:0] d);
        cyc(1'b1, d, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rd();
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    endtask

    // Asynchronous reset taken mid-cycle; outputs must clear before any clock edge.
    task automatic do_reset(input bit ir);
        in_ready = ir; rd_en = 1'b0; flush = 1'b0; clr_ovr = 1'b0; in_data = 8'h00;
        #2 rst_n = 1'b0;
        #1;
        check("rst_count",    32'(count),    32'd0);
        check("rst_empty",    32'(empty),    32'd1);
        check("rst_full",     32'(full),     32'd0);
        check("rst_thresh",   32'(thresh),   32'd0);
        check("rst_overrun",  32'(overrun),  32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data",  32'(rd_data),  32'h00);
        q.delete();
        m_ovr = 1'b0; m_vld = 1'b0; m_data = 8'h00; m_prev = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        // Receiver level high through reset release: nothing captured until it falls and rises.
        do_reset(1'b1);
        cyc(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
        check("no_capture_high", 32'(count), 32'd0);
        cyc(1'b0, 8'h99, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        check("capture_after_rise", 32'(count), 32'd1);
        cyc(1'b0, 8'h11, 1'b1, 1'b0, 1'b0);
        check("first_byte", 32'(rd_data), 32'h11);

        // Two bytes out in order; read on empty is ignored.
        wr(8'hA5); wr(8'h3C);
        rd(); check("rd_a5", 32'(rd_data), 32'hA5);
        rd(); check("rd_3c", 32'(rd_data), 32'h3C);
        rd(); check("rd_empty_hold", 32'(rd_data), 32'h3C);
        check("rd_empty_novld", 32'(rd_valid), 32'd0);

        // Fill to full, overflow once, drain in order, then clear overrun.
        for (int i = 0; i < 16; i++) wr(8'(i));
        check("full_16", 32'(full), 32'd1);
        wr(8'hFF);
        check("ovr_drop", 32'(overrun), 32'd1);
        for (int i = 0; i < 16; i++) begin
            rd(); check("drain_order", 32'(rd_data), 32'(i));
        end
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("clr_ovr", 32'(overrun), 32'd0);

        // Full with a simultaneous write and read: oldest out, new byte kept, no overrun.
        for (int i = 0; i < 16; i++) wr(8'(8'h40 + i));
        cyc(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
        check("full_rw_data", 32'(rd_data), 32'h40);
        check("full_rw_count", 32'(count), 32'd16);
        check("full_rw_ovr", 32'(overrun), 32'd0);
        cyc(1'b0, 8'h77, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) rd();
        check("full_rw_last", 32'(rd_data), 32'h77);

        // Pointer wrap: two rounds of ten bytes.
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 10; i++) wr(8'($urandom));
            for (int i = 0; i < 10; i++) rd();
        end

        // Flush with a concurrent write and read at count 5, overrun set.
        for (int i = 0; i < 17; i++) wr(8'(8'h80 + i));
        for (int i = 0; i < 11; i++) rd();
        check("pre_flush_count", 32'(count), 32'd5);
        check("pre_flush_ovr", 32'(overrun), 32'd1);
        cyc(1'b1, 8'h55, 1'b1, 1'b1, 1'b0);
        check("flush_count", 32'(count), 32'd0);
        check("flush_vld", 32'(rd_valid), 32'd0);
        check("flush_ovr", 32'(overrun), 32'd0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check("flush_discard", 32'(rd_valid), 32'd0);

        // Randomized traffic with phases biased toward filling and draining.
        for (int n = 0; n < 3000; n++) begin
            int wr_pct;
            wr_pct = ((n / 200) % 2 == 0) ? 80 : 30;
            if (n == 1500) do_reset(1'($urandom_range(0, 1)));
            cyc(bit'($urandom_range(0, 99) < wr_pct), 8'($urandom),
                bit'($urandom_range(0, 99) < (100 - wr_pct) / 2),
                bit'($urandom_range(0, 299) == 0),
                bit'($urandom_range(0, 29) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
